// File: rtl/nems_cfg_ctrl_if.sv
// nems_cfg_ctrl_if: command word handshake channel into the relay configuration controller
interface nems_cfg_ctrl_if #(parameter int ROWS = 30);
    logic            in_valid;
    logic            in_ready;
    logic [4:0]      in_col;
    logic [ROWS-1:0] in_rows;
    logic            in_erase;
    modport master(output in_valid, in_col, in_rows, in_erase, input in_ready);
    modport slave(input in_valid, in_col, in_rows, in_erase, output in_ready);
endinterface

// File: rtl/nems_cfg_ctrl.sv
// nems_cfg_ctrl: sequences NEMS relay row/column programming pulses; erase via NEMS_CFG_ERASE_EN
// All outputs are registered so the relay array drive never glitches.
module nems_cfg_ctrl #(
    parameter int ROWS      = 30,
    parameter int COLS      = 29,
    parameter int SETUP_CYC = 2,
    parameter int PULSE_CYC = 16,
    parameter int HOLD_CYC  = 2
) (
    input  logic            cfg_clk,
    input  logic            rst,
    nems_cfg_ctrl_if.slave  cmd,
    output logic [ROWS-1:0] cfgrows,
    output logic [COLS-1:0] cfgcols,
    output logic            busy,
    output logic            done,
    output logic            err,
    output logic [7:0]      prog_cnt
);
    localparam int MAX_CYC = (SETUP_CYC > PULSE_CYC) ?
                             ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC) :
                             ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int CW = $clog2(MAX_CYC) + 1;
    localparam logic [5:0] COLS_W = 6'(COLS);
    localparam logic [COLS-1:0] ONE = COLS'(1);
    typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, ERASE} state_t;
    state_t          state;
    logic [CW-1:0]   cnt;
    logic [4:0]      col_q;
    logic            rdy;
    logic            accept;
    logic            bad_col;
    assign cmd.in_ready = rdy;
    assign accept  = cmd.in_valid && rdy;
    assign bad_col = {1'b0, cmd.in_col} >= COLS_W;
    always_ff @(posedge cfg_clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            col_q    <= '0;
            rdy      <= 1'b0;
            cfgrows  <= '0;
            cfgcols  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            prog_cnt <= '0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
`ifdef NEMS_CFG_ERASE_EN
                        if (cmd.in_erase) begin
                            state   <= ERASE;
                            cnt     <= CW'(PULSE_CYC - 1);
                            cfgcols <= '1;
                            cfgrows <= '0;
                            busy    <= 1'b1;
                            rdy     <= 1'b0;
                        end else
`endif
                        if (cmd.in_erase || bad_col) begin
                            err <= 1'b1;
                        end else begin
                            state   <= SETUP;
                            cnt     <= CW'(SETUP_CYC - 1);
                            col_q   <= cmd.in_col;
                            cfgrows <= cmd.in_rows;
                            busy    <= 1'b1;
                            rdy     <= 1'b0;
                        end
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state   <= PULSE;
                        cnt     <= CW'(PULSE_CYC - 1);
                        cfgcols <= ONE << col_q;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                PULSE: begin
                    if (cnt == '0) begin
                        state   <= HOLD;
                        cnt     <= CW'(HOLD_CYC - 1);
                        cfgcols <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        cfgrows  <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        rdy      <= 1'b1;
                        prog_cnt <= prog_cnt + 8'(prog_cnt != 8'hFF);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`ifdef NEMS_CFG_ERASE_EN
                ERASE: begin
                    if (cnt == '0) begin
                        state    <= IDLE;
                        cfgcols  <= '0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        rdy      <= 1'b1;
                        prog_cnt <= '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_nems_cfg_ctrl.sv
// tb_nems_cfg_ctrl: table-driven and scoreboarded cycle check of nems_cfg_ctrl
module tb_nems_cfg_ctrl;
    localparam int ROWS = 30;
    localparam int COLS = 29;
    localparam int S = 2;
    localparam int P = 16;
    localparam int H = 2;
    localparam int LAT = 1 + S + P + H;
`ifdef NEMS_CFG_ERASE_EN
    localparam bit ERASE_EN = 1'b1;
`else
    localparam bit ERASE_EN = 1'b0;
`endif

    logic cfg_clk = 1'b0;
    logic rst = 1'b1;
    logic [ROWS-1:0] cfgrows;
    logic [COLS-1:0] cfgcols;
    logic busy, done, err;
    logic [7:0] prog_cnt;

    nems_cfg_ctrl_if #(.ROWS(ROWS)) cmd();

    nems_cfg_ctrl #(.ROWS(ROWS), .COLS(COLS), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H)) dut (
        .cfg_clk(cfg_clk), .rst(rst), .cmd(cmd), .cfgrows(cfgrows), .cfgcols(cfgcols),
        .busy(busy), .done(done), .err(err), .prog_cnt(prog_cnt)
    );

    always #5 cfg_clk = ~cfg_clk;

    typedef struct {
        logic [4:0]      col;
        logic [ROWS-1:0] rows;
        bit              erase;
        bit              exp_err;
    } vec_t;

    typedef struct {
        int              hs;
        bit              err;
        bit              erase;
        logic [4:0]      col;
        logic [ROWS-1:0] rows;
    } sb_t;

    sb_t sb[$];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    bit mon_en = 1'b0;
    logic [7:0] mprog = 8'd0;

    always @(posedge cfg_clk) cyc++;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            if (bad < 40) $display("FAIL %s got=%0h exp=%0h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Cycle-exact reference of the output bundle, keyed off each handshake.
    always @(negedge cfg_clk) begin
        int k;
        bit pop;
        logic [ROWS-1:0] e_rows;
        logic [COLS-1:0] e_cols, one;
        logic e_busy, e_done, e_err, e_rdy;
        logic [7:0] e_prog;
        if (mon_en) begin
            one = 1;
            e_rows = '0; e_cols = '0; e_busy = 0; e_done = 0; e_err = 0; e_rdy = 1;
            e_prog = mprog; pop = 0; k = 0;
            if (sb.size() > 0 && cyc >= sb[0].hs) begin
                k = cyc - sb[0].hs + 1;
                if (sb[0].err) begin
                    e_err = 1; pop = 1;
                end else if (sb[0].erase) begin
                    if (k <= P) begin
                        e_cols = '1; e_busy = 1; e_rdy = 0;
                    end else begin
                        e_done = 1; mprog = 8'd0; e_prog = 8'd0; pop = 1;
                    end
                end else if (k < LAT) begin
                    e_rows = sb[0].rows;
                    e_cols = (k > S && k <= S + P) ? one << sb[0].col : '0;
                    e_busy = 1; e_rdy = 0;
                end else begin
                    e_done = 1;
                    mprog = (mprog == 8'hFF) ? mprog : mprog + 8'd1;
                    e_prog = mprog; pop = 1;
                end
            end
            chk($sformatf("outputs k=%0d", k),
                128'({cfgrows, cfgcols, busy, done, err, cmd.in_ready, prog_cnt}),
                128'({e_rows, e_cols, e_busy, e_done, e_err, e_rdy, e_prog}));
            if (pop) void'(sb.pop_front());
        end
    end

    task automatic send_seq(input logic [4:0] col, input logic [ROWS-1:0] rows,
                            input bit erase, input bit exp_err, input int n);
        int pushed = 0;
        int guard = 0;
        int prev_hs = -1;
        @(posedge cfg_clk); #2;
        cmd.in_valid = 1'b1; cmd.in_col = col; cmd.in_rows = rows; cmd.in_erase = erase;
        while (pushed < n && guard < n * (LAT + 10) + 100) begin
            @(negedge cfg_clk);
            if (cmd.in_ready) begin
                sb.push_back('{cyc + 1, exp_err, erase, col, rows});
                if (prev_hs >= 0 && !exp_err) chk("b2b gap", 128'(cyc + 1 - prev_hs), 128'(LAT));
                prev_hs = cyc + 1;
                pushed++;
            end
            guard++;
        end
        if (pushed < n) chk("handshake timeout", 128'(pushed), 128'(n));
        @(posedge cfg_clk); #1;
        cmd.in_valid = 1'b0;
    endtask

    task automatic drain(input int limit);
        int g = 0;
        while (sb.size() > 0 && g < limit) begin
            @(negedge cfg_clk);
            g++;
        end
        if (sb.size() > 0) chk("drain timeout", 128'(sb.size()), 128'(0));
        repeat (2) @(negedge cfg_clk);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{5'd3,  30'h2AAAAAAA, 1'b0, 1'b0};
        vecs[1] = '{5'd29, 30'h3FFFFFFF, 1'b0, 1'b1};
        vecs[2] = '{5'd0,  30'h00000001, 1'b0, 1'b0};
        vecs[3] = '{5'd28, 30'h3FFFFFFF, 1'b0, 1'b0};
        vecs[4] = '{5'd31, 30'h00000000, 1'b0, 1'b1};
        vecs[5] = '{5'd5,  30'h0000FFFF, 1'b1, !ERASE_EN};
        vecs[6] = '{5'd10, 30'h15555555, 1'b0, 1'b0};
        vecs[7] = '{5'd30, 30'h12345678, 1'b0, 1'b1};
        cmd.in_valid = 1'b0; cmd.in_col = '0; cmd.in_rows = '0; cmd.in_erase = 1'b0;

        repeat (3) @(negedge cfg_clk);
        chk("reset outputs", 128'({cfgrows, cfgcols, busy, done, err, cmd.in_ready, prog_cnt}), 128'(0));
        rst = 1'b0;
        #1 chk("ready before edge", 128'(cmd.in_ready), 128'(0));
        @(posedge cfg_clk); #1;
        chk("ready after release", 128'(cmd.in_ready), 128'(1));

        // Reset during the column pulse of a write.
        @(posedge cfg_clk); #2;
        cmd.in_valid = 1'b1; cmd.in_col = 5'd4; cmd.in_rows = 30'h0F0F0F0F;
        @(posedge cfg_clk); #1;
        cmd.in_valid = 1'b0;
        repeat (9) @(posedge cfg_clk);
        #1 chk("pulse before rst", 128'(cfgcols), 128'(29'h10));
        rst = 1'b1;
        #1 chk("async clear", 128'({cfgrows, cfgcols, busy, done, prog_cnt}), 128'(0));
        @(negedge cfg_clk); @(negedge cfg_clk);
        rst = 1'b0;
        #1 chk("ready held low", 128'(cmd.in_ready), 128'(0));
        @(posedge cfg_clk); #1;
        chk("ready one edge after", 128'(cmd.in_ready), 128'(1));
        mon_en = 1'b1;
        repeat (30) @(negedge cfg_clk);

        for (int i = 0; i < 8; i++) begin
            send_seq(vecs[i].col, vecs[i].rows, vecs[i].erase, vecs[i].exp_err, 1);
            drain(100);
        end

        send_seq(5'd7, 30'h3C3C3C3C, 1'b0, 1'b0, 2);
        drain(100);

        send_seq(5'd1, 30'h00000003, 1'b0, 1'b0, 300);
        drain(LAT * 310);
        chk("prog_cnt saturated", 128'(prog_cnt), 128'(255));

        send_seq(5'd2, 30'h3FFFFFFF, 1'b1, !ERASE_EN, 1);
        drain(100);
        chk("prog_cnt after erase", 128'(prog_cnt), ERASE_EN ? 128'(0) : 128'(255));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/nems_cfg_ctrl.md
NEMS_CFG_CTRL -- requirements
Module: nems_cfg_ctrl

Interface
REQ-001 Parameter ROWS, default 30, width of the relay row-select bus.
REQ-002 Parameter COLS, default 29, width of the relay column-select bus.
REQ-003 Parameter SETUP_CYC, default 2, cycles rows are driven before the column pulse.
REQ-004 Parameter PULSE_CYC, default 16, column pulse width in cycles.
REQ-005 Parameter HOLD_CYC, default 2, cycles rows are held after the column pulse.
REQ-006 cfg_clk  in  1  sole clock; all state is updated on its rising edge.
REQ-007 rst  in  1  asynchronous reset, active-high.
REQ-008 in_valid  in  1  command word valid.
REQ-009 in_ready  out  1  controller accepts a word when in_valid and in_ready are both high.
REQ-010 in_col  in  5  target column index.
REQ-011 in_rows  in  ROWS  row pattern; 1 = close the relay at (row, in_col).
REQ-012 in_erase  in  1  erase command; in_col and in_rows are ignored.
REQ-013 cfgrows  out  ROWS  row drive to the relay array.
REQ-014 cfgcols  out  COLS  column drive to the relay array; at most one bit is high except during an erase.
REQ-015 busy  out  1  high in every state except IDLE.
REQ-016 done  out  1  one-cycle pulse when a command completes.
REQ-017 err  out  1  one-cycle pulse when a command is rejected.
REQ-018 prog_cnt  out  8  count of completed column writes; saturates at 255.

Function
REQ-019 FSM states: IDLE, SETUP, PULSE, HOLD, ERASE.
REQ-020 in_ready is high only in IDLE; a word is accepted on the handshake edge only.
REQ-021 IDLE with an accepted write and in_col < COLS: latch in_col and in_rows; drive cfgrows = in_rows on the next cycle; go to SETUP.
REQ-022 IDLE with an accepted write and in_col >= COLS: assert err for one cycle the next cycle; stay in IDLE; cfgrows and cfgcols are unchanged (zero).
REQ-023 SETUP lasts exactly SETUP_CYC cycles with cfgcols = 0, then the FSM enters PULSE.
REQ-024 PULSE lasts exactly PULSE_CYC cycles with cfgcols = one-hot(latched col) and cfgrows held, then the FSM enters HOLD.
REQ-025 HOLD lasts exactly HOLD_CYC cycles with cfgcols = 0 and cfgrows held; on exit, cfgrows = 0, done pulses, prog_cnt increments (saturating), and the FSM returns to IDLE.
REQ-026 Write latency from the handshake edge to done is 1+SETUP_CYC+PULSE_CYC+HOLD_CYC cycles: 21 at the defaults.
REQ-027 A single down-counter, width ceil(log2(max cycle parameter))+1, times every state; it reloads on each state entry.
REQ-028 The FSM accepts no new word while busy; in_valid held high during busy has no effect until IDLE.
REQ-029 Back-to-back: a word presented in the cycle in which done is high is accepted (in_ready=1 in IDLE); there is no idle bubble beyond that cycle.
REQ-030 All outputs are registered; cfgrows and cfgcols carry no glitches.

Reset
REQ-031 While rst is high: state=IDLE, cfgrows=0, cfgcols=0, busy=0, done=0, err=0, prog_cnt=0, in_ready=0.
REQ-032 in_ready rises on the first cfg_clk edge after rst falls.
REQ-033 rst asserted mid-PULSE zeroes cfgcols asynchronously; the interrupted write produces no done and no prog_cnt change.

Configuration
REQ-034 Macro NEMS_CFG_ERASE_EN.
REQ-035 With NEMS_CFG_ERASE_EN defined, an accepted in_erase word enters ERASE for PULSE_CYC cycles with cfgcols = all ones and cfgrows = 0. On exit: done pulses, prog_cnt resets to 0, the FSM returns to IDLE.
REQ-036 With NEMS_CFG_ERASE_EN undefined, an accepted in_erase word is rejected like REQ-022 (err pulse, no drive); the ERASE state logic is absent.

Verification
REQ-037 Write col=3, rows=30'h2AAAAAAA -> cfgrows=2AAAAAAA from cycle 1; cfgcols=29'h8 in cycles 3-18; done at cycle 21; prog_cnt=1.
REQ-038 Write col=29 -> err pulse one cycle later; no cfgcols activity; busy stays 0.
REQ-039 Two words back-to-back with in_valid held high -> second handshake in the done cycle; cfgcols is never two-hot; prog_cnt=2.
REQ-040 rst pulsed at cycle 10 of a write -> cfgcols=0 immediately; no done; prog_cnt unchanged; in_ready=1 one edge after release.
REQ-041 300 writes -> prog_cnt saturates at 255.
REQ-042 Erase word: with NEMS_CFG_ERASE_EN -> cfgcols all ones for 16 cycles, cfgrows=0, prog_cnt=0; without it -> err pulse only.
